// File: rtl/alu_pkg.sv
// Shared definitions for the ALU arbitration controller.
//   - 4-bit ALU opcode constants (0..9)
//   - controller FSM state encoding
//   - op_supported(): opcodes whose results are returned as valid data
package alu_pkg;

  localparam logic [3:0] OP_AND      = 4'd0;
  localparam logic [3:0] OP_OR       = 4'd1;
  localparam logic [3:0] OP_ADD      = 4'd2;
  localparam logic [3:0] OP_HALF_SUB = 4'd3;
  localparam logic [3:0] OP_ABS_SUB  = 4'd4;
  localparam logic [3:0] OP_SUB      = 4'd5;
  localparam logic [3:0] OP_MUL      = 4'd6;
  localparam logic [3:0] OP_DIV_MUL  = 4'd7;
  localparam logic [3:0] OP_MIN      = 4'd8;
  localparam logic [3:0] OP_MAX      = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // MUL, DIV-MUL and the undefined codes 10-15 are still sequenced
  // through the ALU, but their result is reported as an error.
  function automatic logic op_supported(input logic [3:0] op);
    return (op <= OP_MAX) && (op != OP_MUL) && (op != OP_DIV_MUL);
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-requester round-robin arbiter (purely combinational).
//   req  [1:0]  request vector
//   ptr         index of the requester favoured when both request
//   gnt  [1:0]  one-hot grant (all zero when nothing requests)
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = 2'b00;
    if (req == 2'b11) begin
      gnt = ptr ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

endmodule

// File: rtl/alu_arb_ctrl.sv
// ALU arbitration controller: accepts operations from two requesters,
// sequences each through an external combinational ALU and returns a
// one-cycle response.
//
// Parameters: CONST_VAL (constant B operand), CNT_W (grant counter width)
// Ports:
//   clk, reset (synchronous, active low)
//   req0_*/req1_*  : valid, ready, op, a, b, use_const per requester
//   alu_*          : operand/opcode/enable outputs, alu_result input
//   rsp_*          : valid strobe, requester id, data, error flag
//   gnt_cnt0/1     : accepted-request counters
//   fsm_state      : current controller state (debug visibility)
// Build option: define ALU_ARB_STATS_EN to implement the saturating grant
// counters; otherwise the counter outputs are tied to zero.
//
// Handshake: an operation is accepted on a rising edge where valid and
// ready are both high. Ready is only raised in IDLE, to at most one
// requester, and depends combinationally on the valids; a requester may
// drop valid at any time before acceptance. Responses are not backpressured.
module alu_arb_ctrl
  import alu_pkg::*;
#(
  parameter logic [7:0] CONST_VAL = 8'd1,
  parameter int         CNT_W     = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_op,
  input  logic [7:0]       req0_a,
  input  logic [7:0]       req0_b,
  input  logic             req0_use_const,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_op,
  input  logic [7:0]       req1_a,
  input  logic [7:0]       req1_b,
  input  logic             req1_use_const,
  output logic [7:0]       alu_data_1,
  output logic [7:0]       alu_data_2,
  output logic             alu_input_select,
  output logic [3:0]       alu_selector,
  output logic [7:0]       alu_content,
  output logic             alu_enable,
  input  logic [15:0]      alu_result,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [15:0]      rsp_data,
  output logic             rsp_err,
  output logic [CNT_W-1:0] gnt_cnt0,
  output logic [CNT_W-1:0] gnt_cnt1,
  output state_t           fsm_state
);

  state_t      state, state_nxt;
  logic        ptr;
  logic [1:0]  gnt;
  logic        hs;
  logic        hs_id;
  logic [3:0]  op_q;
  logic [7:0]  a_q, b_q;
  logic        const_q;
  logic        id_q;
  logic [15:0] rsp_data_q;
  logic        rsp_err_q;

  rr_arb2 u_arb (
    .req (/* */ {req1_valid, req0_valid}),
    .ptr (ptr),
    .gnt (gnt)
  );

  assign req0_ready = (state == ST_IDLE) && gnt[0];
  assign req1_ready = (state == ST_IDLE) && gnt[1];
  // Grants are one-hot and only given to valid requesters.
  assign hs         = req0_ready || req1_ready;
  assign hs_id      = req1_ready;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (hs) state_nxt = ST_EXEC;
      ST_EXEC: state_nxt = ST_RESP;
      ST_RESP: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      op_q       <= 4'd0;
      a_q        <= 8'd0;
      b_q        <= 8'd0;
      const_q    <= 1'b0;
      id_q       <= 1'b0;
      rsp_data_q <= 16'd0;
      rsp_err_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (hs) begin
        // Favour the other requester next time both are valid.
        ptr     <= ~hs_id;
        id_q    <= hs_id;
        op_q    <= hs_id ? req1_op        : req0_op;
        a_q     <= hs_id ? req1_a         : req0_a;
        b_q     <= hs_id ? req1_b         : req0_b;
        const_q <= hs_id ? req1_use_const : req0_use_const;
      end
      if (state == ST_EXEC) begin
        if (op_supported(op_q)) begin
          rsp_data_q <= alu_result;
          rsp_err_q  <= 1'b0;
        end else begin
          rsp_data_q <= 16'd0;
          rsp_err_q  <= 1'b1;
        end
      end
    end
  end

  // ALU operands come only from the accepted-operation registers.
  assign alu_data_1       = a_q;
  assign alu_data_2       = b_q;
  assign alu_input_select = const_q;
  assign alu_selector     = op_q;
  assign alu_content      = CONST_VAL;
  assign alu_enable       = (state == ST_EXEC);

  assign rsp_valid = (state == ST_RESP);
  assign rsp_id    = id_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign fsm_state = state;

`ifdef ALU_ARB_STATS_EN
  logic [CNT_W-1:0] cnt0_q, cnt1_q;

  always_ff @(posedge clk) begin
    if (!reset) begin
      cnt0_q <= '0;
      cnt1_q <= '0;
    end else begin
      if (req0_ready && (cnt0_q != '1)) cnt0_q <= cnt0_q + CNT_W'(1);
      if (req1_ready && (cnt1_q != '1)) cnt1_q <= cnt1_q + CNT_W'(1);
    end
  end

  assign gnt_cnt0 = cnt0_q;
  assign gnt_cnt1 = cnt1_q;
`else
  assign gnt_cnt0 = '0;
  assign gnt_cnt1 = '0;
`endif

endmodule

// File: doc/alu_arb_ctrl.md
ALU_ARB_CTRL -- requirements
Module: alu_arb_ctrl

Interface
REQ-001 Parameter: CONST_VAL, 8'd1, constant driven on alu_content when a request selects the constant operand.
REQ-002 Parameter: CNT_W, 16, width of the grant statistics counters.
REQ-003 clk  in  1  single clock; all state updates on its rising edge.
REQ-004 reset  in  1  synchronous, active-low reset (reset==0 at a rising clk edge resets the block).
REQ-005 req0_valid / req1_valid  in  1  requester 0/1 has an operation pending.
REQ-006 req0_ready / req1_ready  out  1  requester 0/1 operation accepted this cycle (valid & ready = handshake).
REQ-007 req0_op / req1_op  in  4  ALU opcode (0 AND, 1 OR, 2 ADD, 3 halved SUB, 4 ABS SUB, 5 SUB, 6 MUL, 7 DIV-MUL, 8 MIN, 9 MAX).
REQ-008 req0_a, req0_b / req1_a, req1_b  in  8 each  operands A and B.
REQ-009 req0_use_const / req1_use_const  in  1  1: operand B replaced by CONST_VAL.
REQ-010 alu_data_1, alu_data_2  out  8 each  operands to the ALU datapath.
REQ-011 alu_input_select  out  1  ALU B-operand select (1 = constant path).
REQ-012 alu_selector  out  4  ALU opcode.
REQ-013 alu_content  out  8  constant operand to the ALU.
REQ-014 alu_enable  out  1  high during the ALU execute cycle.
REQ-015 alu_result  in  16  combinational ALU result.
REQ-016 rsp_valid  out  1  one-cycle response strobe; rsp_id  out  1  requester index; rsp_data  out  16  result; rsp_err  out  1  opcode not supported.
REQ-017 gnt_cnt0, gnt_cnt1  out  CNT_W  accepted-request counters per requester.

Function
REQ-018 FSM states IDLE, EXEC, RESP; IDLE->EXEC on handshake, EXEC->RESP unconditionally, RESP->IDLE unconditionally.
REQ-019 Readies asserted only in IDLE, at most one per cycle, to the arbitration winner; readies are combinational from valids and the priority pointer.
REQ-020 Arbitration: round-robin; both valid -> grant the requester not granted last; one valid -> grant it; pointer updates only on handshake.
REQ-021 On handshake, op, a, b, use_const and requester id are registered; the ALU ports are driven from these registers only (no input-to-ALU combinational path).
REQ-022 In EXEC: alu_enable=1; alu_result captured into rsp_data at the end of EXEC.
REQ-023 In RESP: rsp_valid=1 for exactly one cycle with rsp_id, rsp_data, rsp_err; no response backpressure.
REQ-024 Latency: handshake at edge N -> rsp_valid high during cycle N+2; throughput one operation per 3 cycles.
REQ-025 Opcodes 6, 7 and 10-15: operation still sequenced, rsp_data=16'd0 regardless of alu_result, rsp_err=1.
REQ-026 Outside EXEC: alu_enable=0; other ALU outputs hold last registered values.
REQ-027 Valids dropped before handshake are ignored; no requirement on requesters to hold valid.

Reset
REQ-028 On reset: state IDLE, pointer favours requester 0, all registered operands/opcode 0, rsp_valid=0, rsp_id=0, rsp_data=0, rsp_err=0, alu_enable=0, counters 0.
REQ-029 Reset in EXEC or RESP abandons the operation; no response is issued for it.

Configuration
REQ-030 Macro ALU_ARB_STATS_EN defined: gnt_cnt0/gnt_cnt1 increment on each handshake of their requester, saturating at all-ones.
REQ-031 Macro ALU_ARB_STATS_EN undefined: counter logic absent, gnt_cnt0/gnt_cnt1 ports present and tied to 0.

Structure
REQ-032 Shared package alu_pkg holds the 4-bit opcode constants (0-9), FSM state encoding and the supported-opcode check.
REQ-033 Round-robin grant logic is one sub-module, rr_arb2 (2 requests, pointer in, one-hot grant out).

Verification
REQ-034 Single request: req0 ADD a=200, b=100 -> req0_ready at N, rsp_valid at N+2, rsp_id=0, rsp_data=16'h012C, rsp_err=0.
REQ-035 Constant path: CONST_VAL=8'd5, req1 SUB a=3, use_const=1 -> alu_input_select=1, alu_content=5, rsp_data=16'hFFFE, rsp_id=1.
REQ-036 Contention: both valid continuously for 4 ops -> grants 0,1,0,1; rsp_id sequence 0,1,0,1; one response per 3 cycles.
REQ-037 Unsupported op: req0 op=6 a=4 b=4 -> rsp_data=0, rsp_err=1; op=12 -> same.
REQ-038 Reset mid-op: reset=0 during EXEC -> no rsp_valid, state IDLE, next contention grants requester 0.
REQ-039 Stats (ALU_ARB_STATS_EN, CNT_W=2): 5 req0 handshakes -> gnt_cnt0=3 (saturated), gnt_cnt1=0; without macro both read 0.
